sccb_cfg_seq: RTL

//  Power-up configuration sequencer for the SCCB master. Walks a register table (external sync ROM),

---
 rtl/sccb_pkg.sv | 22 ++
 rtl/sccb_dly_timer.sv | 42 ++++
 rtl/sccb_cfg_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// Shared types and table marker encodings for the SCCB configuration sequencer.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_FETCH,
    ST_DECODE,
    ST_DELAY,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [15:0] TBL_END = 16'hFFFF;
  localparam logic [7:0]  TBL_DLY = 8'hFE;

endpackage

// File: rtl/sccb_dly_timer.sv
// Unit delay timer: load a unit count, count DLY_CYC clocks per unit, pulse expire on the last cycle.
module sccb_dly_timer #(
  parameter int DLY_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] units,
  output logic       expire
);

  localparam int CW = (DLY_CYC > 1) ? $clog2(DLY_CYC) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(DLY_CYC - 1);

  logic [CW-1:0] cyc;
  logic [7:0]    left;
  logic          run;

  // Combinational so the owner can leave its wait state on the final counted cycle.
  assign expire = run && (cyc == CYC_LAST) && (left == 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      run  <= 1'b0;
      cyc  <= '0;
      left <= '0;
    end else if (load) begin
      run  <= (units != 8'd0);
      cyc  <= '0;
      left <= units;
    end else if (run) begin
      if (cyc == CYC_LAST) begin
        cyc  <= '0;
        left <= left - 8'd1;
        if (left == 8'd1) run <= 1'b0;
      end else begin
        cyc <= cyc + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sccb_cfg_seq.sv
// Power-up register table walker: one SCCB write per entry, optional readback compare with retry.
module sccb_cfg_seq
  import sccb_pkg::*;
#(
  parameter int IDX_W      = 6,
  parameter int DLY_CYC    = 50000,
  parameter int PWRUP_UNIT = 20,
  parameter int VERIFY     = 1,
  parameter int MAX_RETRY  = 3,
  parameter int TO_CYC     = 200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W-1:0] err_idx,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [15:0]      tbl_rdata,
  output logic [7:0]       addr,
  output logic [7:0]       wdata,
  output logic             wr_en,
  output logic             rd_en,
  input  logic [7:0]       rdata,
  input  logic             rdata_vld,
  input  logic             rdy
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);
  localparam logic [7:0]    PWR_U     = 8'(PWRUP_UNIT);

  state_t           state, nxt;
  logic [IDX_W-1:0] idx;
  logic [RW-1:0]    retry;
  logic [TW-1:0]    to_cnt;
  logic             seen_low;
  logic [7:0]       rd_q;

  logic       dly_load, dly_exp;
  logic [7:0] dly_units;
  logic       idx_clr, idx_inc, retry_clr, retry_inc;
  logic       to_clr, ent_lat, rd_lat, err_lat;
  logic       adv, fail;
  logic       in_wait, timeout, is_last;

  assign in_wait = (state == ST_WR_WAIT) || (state == ST_RD_WAIT);
  assign timeout = in_wait && (to_cnt == TO_LAST);
  assign is_last = &idx;

  assign tbl_idx = idx;
  assign busy    = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign done    = (state == ST_DONE);
  assign err     = (state == ST_ERR);

  sccb_dly_timer #(.DLY_CYC(DLY_CYC)) u_dly (
    .clk    (clk),
    .rst    (rst),
    .load   (dly_load),
    .units  (dly_units),
    .expire (dly_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    dly_load  = 1'b0;
    dly_units = tbl_rdata[7:0];
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    retry_clr = 1'b0;
    retry_inc = 1'b0;
    to_clr    = 1'b0;
    ent_lat   = 1'b0;
    rd_lat    = 1'b0;
    err_lat   = 1'b0;
    adv       = 1'b0;
    fail      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          idx_clr   = 1'b1;
          retry_clr = 1'b1;
          if (PWR_U == 8'd0) begin
            nxt = ST_FETCH;
          end else begin
            dly_load  = 1'b1;
            dly_units = PWR_U;
            nxt       = ST_PWRUP;
          end
        end
      end
      ST_PWRUP:  if (dly_exp) nxt = ST_FETCH;
      ST_FETCH:  nxt = ST_DECODE;
      ST_DECODE: begin
        if (tbl_rdata == TBL_END) begin
          nxt = ST_DONE;
        end else if (tbl_rdata[15:8] == TBL_DLY) begin
          if (tbl_rdata[7:0] == 8'd0) begin
            adv = 1'b1;
          end else begin
            dly_load = 1'b1;
            nxt      = ST_DELAY;
          end
        end else begin
          ent_lat = 1'b1;
          nxt     = ST_WR_REQ;
        end
      end
      ST_DELAY: if (dly_exp) adv = 1'b1;
      ST_WR_REQ: begin
        if (rdy) begin
          wr_en  = 1'b1;
          to_clr = 1'b1;
          nxt    = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        // Completion is the master going busy and then idle again.
        if (seen_low && rdy) begin
          if (VERIFY != 0) nxt = ST_RD_REQ;
          else             adv = 1'b1;
        end else if (timeout) begin
          fail = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (rdy) begin
          rd_en  = 1'b1;
          to_clr = 1'b1;
          nxt    = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (rdata_vld) begin
          rd_lat = 1'b1;
          nxt    = ST_CHECK;
        end else if (timeout) begin
          fail = 1'b1;
        end
      end
      ST_CHECK: begin
        if (rd_q == wdata) adv  = 1'b1;
        else               fail = 1'b1;
      end
      default: nxt = ST_IDLE;
    endcase

    // The last table slot ends the run even without an end marker.
    if (adv) begin
      retry_clr = 1'b1;
      if (is_last) begin
        nxt = ST_DONE;
      end else begin
        idx_inc = 1'b1;
        nxt     = ST_FETCH;
      end
    end
    if (fail) begin
      if (retry == RETRY_MAX) begin
        err_lat = 1'b1;
        nxt     = ST_ERR;
      end else begin
        retry_inc = 1'b1;
        nxt       = ST_WR_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      retry    <= '0;
      to_cnt   <= '0;
      seen_low <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      rd_q     <= '0;
      err_idx  <= '0;
    end else begin
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + IDX_W'(1);

      if (retry_clr)      retry <= '0;
      else if (retry_inc) retry <= retry + RW'(1);

      if (to_clr) begin
        to_cnt   <= '0;
        seen_low <= 1'b0;
      end else if (in_wait) begin
        to_cnt <= to_cnt + TW'(1);
        if (!rdy) seen_low <= 1'b1;
      end

      if (ent_lat) {addr, wdata} <= tbl_rdata;
      if (rd_lat)  rd_q <= rdata;
      if (err_lat) err_idx <= idx;
    end
  end

endmodule
